parity_bit: RTL and testbench
=============================

PARITY_BIT -- requirements
Module: parity_bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ODD_PARITY, default 1, SHALL select odd parity (1) or even parity (0) for both encode and check.
REQ-003 Parameter CNT_W, default 8, SHALL set the error-counter width.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port initialInput, input, 15 bits: data word to encode.
REQ-007 Port finalOutput, output, 16 bits: combinational encoded word.
REQ-008 Port in_valid, input, 1 bit: initialInput is to be captured this cycle.
REQ-009 Port out_word, output, 16 bits: registered encoded word.
REQ-010 Port out_valid, output, 1 bit: out_word is valid.
REQ-011 Port chk_word, input, 16 bits: received encoded word to check.
REQ-012 Port chk_valid, input, 1 bit: chk_word is to be checked this cycle.
REQ-013 Port chk_error, output, 1 bit: registered parity-error flag.
REQ-014 Port chk_done, output, 1 bit: chk_error is valid.
REQ-015 Port err_count, output, CNT_W bits: count of detected errors.
REQ-016 Port clear_count, input, 1 bit: synchronous clear of err_count.

Function
REQ-017 finalOutput[15:1] SHALL equal initialInput[14:0], and finalOutput[0] SHALL be the parity bit.
- The parity bit SHALL be chosen so the 16-bit word holds an odd number of ones when ODD_PARITY=1, or an even number when ODD_PARITY=0.
REQ-018 finalOutput SHALL be purely combinational, independent of clk and reset_n, and settle within the same delta/propagation window as initialInput changes.
REQ-019 On a clk rise with in_valid=1:
- out_word SHALL load the current finalOutput value.
- out_valid SHALL be 1 in the following cycle.
- This is 1-cycle latency.
REQ-020 On a clk rise with in_valid=0, out_valid SHALL go to 0 and out_word SHALL hold its last value.
REQ-021 On a clk rise with chk_valid=1:
- chk_error SHALL be set to 1 if the XOR of all 16 bits of chk_word mismatches the selected parity (odd: XOR=0 is an error; even: XOR=1 is an error), and 0 otherwise.
- chk_done SHALL be 1 in the following cycle.
REQ-022 On a clk rise with chk_valid=0, chk_done SHALL go to 0 and chk_error SHALL hold its last value.
REQ-023 err_count SHALL increment by 1 on each clk rise where chk_valid=1 and a parity error is detected.
REQ-024 err_count SHALL saturate at all-ones, with no wrap-around.
REQ-025 clear_count=1 SHALL zero err_count on the next clk rise.
- clear_count SHALL take priority over a simultaneous increment.
- The error itself SHALL still be reported on chk_error.
REQ-026 The encode and check paths SHALL be independent. Simultaneous in_valid and chk_valid SHALL both be processed in the same cycle.

Reset
REQ-027 While reset_n=0, the following outputs SHALL be 0 immediately, without waiting for a clock edge: out_word, out_valid, chk_error, chk_done, err_count.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight capture. The first valid output after reset deassertion SHALL come from a capture taken on a clk rise with reset_n=1.
REQ-029 finalOutput SHALL be unaffected by reset_n.

Verification
REQ-030 With ODD_PARITY=1, initialInput=15'h7FFF -> finalOutput=16'hFFFE, with no clock edge needed.
REQ-031 With ODD_PARITY=1, initialInput=15'h0000 -> finalOutput=16'h0001. The ODD_PARITY=0 build SHALL produce 16'hFFFF and 16'h0000 for these two inputs.
REQ-032 Pulse in_valid=1 with initialInput=15'h0001 for one cycle -> next cycle out_valid=1, out_word=16'h0002; the cycle after that, out_valid=0 and out_word holds.
REQ-033 Apply chk_valid=1 with chk_word=16'hFFFE, then 16'hFFFF -> chk_error=0, then 1, each with chk_done=1 the cycle after the input; err_count=1.
REQ-034 With CNT_W=2, inject 5 erroneous words -> err_count sticks at 3. Then assert clear_count together with chk_valid carrying an erroneous word -> err_count=0 and chk_error=1.
REQ-035 Assert reset_n=0 asynchronously between clock edges while out_valid=1 and err_count is nonzero -> all registered outputs are 0 at once, and finalOutput still tracks initialInput.

Source files
------------

// File: rtl/parity_bit.sv
`default_nettype none
// ============================================================================
//  Module   : parity_bit
//  Brief    : 15-bit to 16-bit parity encoder (combinational and registered)
//             plus an independent 16-bit parity checker with a saturating
//             error counter.
//  Revision : 1.0  initial release
// ============================================================================
module parity_bit #(
  parameter bit ODD_PARITY = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  // encode path
  input  logic [14:0]      initialInput,
  output logic [15:0]      finalOutput,
  input  logic             in_valid,
  output logic [15:0]      out_word,
  output logic             out_valid,
  // check path
  input  logic [15:0]      chk_word,
  input  logic             chk_valid,
  output logic             chk_error,
  output logic             chk_done,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Parity bit that completes the selected parity over the 16-bit word.
  // For odd parity the data XOR is inverted so the total count of ones is odd.
  logic enc_parity;
  logic chk_xor;
  logic chk_bad;

  // Encoder and checker parity evaluation; no clock or reset involvement.
  always_comb begin
    enc_parity  = (^initialInput) ^ ODD_PARITY;
    finalOutput = {initialInput, enc_parity};
    chk_xor     = ^chk_word;
    // A legal odd-parity word XORs to 1, a legal even-parity word to 0.
    chk_bad     = chk_xor ^ ODD_PARITY;
  end

  // Registered state and its next-state values.
  logic [15:0]      out_word_q,  out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             chk_error_q, chk_error_d;
  logic             chk_done_q,  chk_done_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Next-state logic: capture on valid, hold otherwise; counter saturates
  // and a clear wins over a same-cycle increment.
  always_comb begin
    out_word_d  = out_word_q;
    out_valid_d = in_valid;
    chk_error_d = chk_error_q;
    chk_done_d  = chk_valid;
    err_count_d = err_count_q;

    if (in_valid) begin
      out_word_d = finalOutput;
    end

    if (chk_valid) begin
      chk_error_d = chk_bad;
    end

    if (clear_count) begin
      err_count_d = '0;
    end else if (chk_valid && chk_bad && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State registers; reset clears everything immediately, dropping any
  // capture that was in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      chk_error_q <= 1'b0;
      chk_done_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      chk_error_q <= chk_error_d;
      chk_done_q  <= chk_done_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign chk_error = chk_error_q;
  assign chk_done  = chk_done_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_bit
//  Brief    : Directed bench for parity_bit: default build, CNT_W=2 build and
//             even-parity build driven from shared stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parity_bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] initialInput;
  logic        in_valid;
  logic [15:0] chk_word;
  logic        chk_valid;
  logic        clear_count;

  // default build (odd parity, 8-bit counter)
  logic [15:0] fo_a, ow_a;
  logic        ov_a, ce_a, cd_a;
  logic [7:0]  ec_a;
  // narrow counter build
  logic [15:0] fo_b, ow_b;
  logic        ov_b, ce_b, cd_b;
  logic [1:0]  ec_b;
  // even parity build
  logic [15:0] fo_e, ow_e;
  logic        ov_e, ce_e, cd_e;
  logic [7:0]  ec_e;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  parity_bit u_dut (
    .clk(clk), .reset_n(reset_n), .initialInput(initialInput), .finalOutput(fo_a),
    .in_valid(in_valid), .out_word(ow_a), .out_valid(ov_a), .chk_word(chk_word),
    .chk_valid(chk_valid), .chk_error(ce_a), .chk_done(cd_a), .err_count(ec_a),
    .clear_count(clear_count)
  );

  parity_bit #(.ODD_PARITY(1'b1), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .reset_n(reset_n), .initialInput(initialInput), .finalOutput(fo_b),
    .in_valid(in_valid), .out_word(ow_b), .out_valid(ov_b), .chk_word(chk_word),
    .chk_valid(chk_valid), .chk_error(ce_b), .chk_done(cd_b), .err_count(ec_b),
    .clear_count(clear_count)
  );

  parity_bit #(.ODD_PARITY(1'b0), .CNT_W(8)) u_dut_even (
    .clk(clk), .reset_n(reset_n), .initialInput(initialInput), .finalOutput(fo_e),
    .in_valid(in_valid), .out_word(ow_e), .out_valid(ov_e), .chk_word(chk_word),
    .chk_valid(chk_valid), .chk_error(ce_e), .chk_done(cd_e), .err_count(ec_e),
    .clear_count(clear_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // watchdog so the bench can never hang
  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    reset_n      = 1'b0;
    initialInput = 15'h0;
    in_valid     = 1'b0;
    chk_word     = 16'h0;
    chk_valid    = 1'b0;
    clear_count  = 1'b0;
    step();
    step();
    check_eq("rst_out_word",  ow_a, 16'h0);
    check_eq("rst_out_valid", ov_a, 1'b0);
    check_eq("rst_chk_error", ce_a, 1'b0);
    check_eq("rst_chk_done",  cd_a, 1'b0);
    check_eq("rst_err_count", ec_a, 8'h0);
    reset_n = 1'b1;

    // combinational encoder, no clock edge between drive and sample
    initialInput = 15'h7FFF; #1;
    check_eq("enc_7fff_odd",  fo_a, 16'hFFFE);
    check_eq("enc_7fff_even", fo_e, 16'hFFFF);
    initialInput = 15'h0000; #1;
    check_eq("enc_0000_odd",  fo_a, 16'h0001);
    check_eq("enc_0000_even", fo_e, 16'h0000);
    initialInput = 15'h1234; #1;  // five ones
    check_eq("enc_1234_odd",  fo_a, 16'h2468);
    check_eq("enc_1234_even", fo_e, 16'h2469);
    initialInput = 15'h5555; #1;  // eight ones
    check_eq("enc_5555_odd",  fo_a, 16'hAAAB);
    check_eq("enc_5555_even", fo_e, 16'hAAAA);
    @(negedge clk);

    // single-cycle capture, then hold
    initialInput = 15'h0001;
    in_valid     = 1'b1;
    step();
    in_valid     = 1'b0;
    initialInput = 15'h7FFF;
    check_eq("cap_valid", ov_a, 1'b1);
    check_eq("cap_word",  ow_a, 16'h0002);
    step();
    check_eq("hold_valid", ov_a, 1'b0);
    check_eq("hold_word",  ow_a, 16'h0002);

    // checker: good word then bad word (odd build)
    chk_valid = 1'b1;
    chk_word  = 16'hFFFE;
    step();
    check_eq("chk_fffe_done", cd_a, 1'b1);
    check_eq("chk_fffe_err",  ce_a, 1'b0);
    check_eq("chk_fffe_even", ce_e, 1'b1);
    chk_word = 16'hFFFF;
    step();
    chk_valid = 1'b0;
    check_eq("chk_ffff_done", cd_a, 1'b1);
    check_eq("chk_ffff_err",  ce_a, 1'b1);
    check_eq("chk_ffff_even", ce_e, 1'b0);
    check_eq("cnt_after_two", ec_a, 8'd1);
    check_eq("cnt_even",      ec_e, 8'd1);
    step();
    check_eq("chk_idle_done", cd_a, 1'b0);
    check_eq("chk_idle_hold", ce_a, 1'b1);

    // encode and check in the same cycle
    in_valid     = 1'b1;
    initialInput = 15'h1234;
    chk_valid    = 1'b1;
    chk_word     = 16'h2468;
    step();
    in_valid  = 1'b0;
    check_eq("sim_word",  ow_a, 16'h2468);
    check_eq("sim_valid", ov_a, 1'b1);
    check_eq("sim_done",  cd_a, 1'b1);
    check_eq("sim_err",   ce_a, 1'b0);

    // five erroneous words: narrow counter saturates, wide one keeps counting
    chk_word = 16'h0000;
    for (int i = 0; i < 5; i++) step();
    chk_valid = 1'b0;
    check_eq("sat_c2",   ec_b, 2'd3);
    check_eq("sat_wide", ec_a, 8'd6);
    step();
    check_eq("sat_c2_hold", ec_b, 2'd3);

    // clear wins over a simultaneous error, error still flagged
    clear_count = 1'b1;
    chk_valid   = 1'b1;
    chk_word    = 16'h0000;
    step();
    clear_count = 1'b0;
    chk_valid   = 1'b0;
    check_eq("clr_c2",   ec_b, 2'd0);
    check_eq("clr_wide", ec_a, 8'd0);
    check_eq("clr_err",  ce_a, 1'b1);

    // build up state, then reset asynchronously mid-cycle
    in_valid     = 1'b1;
    initialInput = 15'h5555;
    chk_valid    = 1'b1;
    chk_word     = 16'h0000;
    step();
    check_eq("pre_rst_valid", ov_a, 1'b1);
    check_eq("pre_rst_cnt",   ec_a, 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_word",  ow_a, 16'h0);
    check_eq("arst_out_valid", ov_a, 1'b0);
    check_eq("arst_chk_error", ce_a, 1'b0);
    check_eq("arst_chk_done",  cd_a, 1'b0);
    check_eq("arst_err_count", ec_a, 8'h0);
    initialInput = 15'h7FFF; #1;
    check_eq("arst_enc", fo_a, 16'hFFFE);
    @(posedge clk);  // captures with reset held must be ignored
    #1;
    check_eq("arst_edge_valid", ov_a, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    chk_valid = 1'b0;
    reset_n   = 1'b1;
    step();
    check_eq("post_rst_valid", ov_a, 1'b0);
    check_eq("post_rst_word",  ow_a, 16'h0);
    in_valid     = 1'b1;
    initialInput = 15'h0000;
    step();
    in_valid = 1'b0;
    check_eq("post_rst_cap_valid", ov_a, 1'b1);
    check_eq("post_rst_cap_word",  ow_a, 16'h0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
